// File: rtl/sub0_bit_pkg.sv
// Shared definitions for the sub0 bit-collect stage: group count, byte width,
// FSM encoding and the FIFO entry layout {mask, bits}.
package sub0_bit_pkg;

   localparam int BIT_GROUP_NUM = 4;
   localparam int BIT_WIDTH     = 8;
   localparam int BIT_IDX_W     = $clog2(BIT_WIDTH);
   localparam int ENTRY_W       = 2 * BIT_GROUP_NUM;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_e;

   // A disabled group contributes 0 regardless of byte and index.
   function automatic logic sel_bit(input logic [BIT_WIDTH-1:0] data,
                                    input logic [BIT_IDX_W-1:0] idx,
                                    input logic                 en);
      return en & data[idx];
   endfunction

endpackage

// File: rtl/sub0_sync_fifo.sv
// Small synchronous FIFO with a registered head (dout) so the consumer sees
// flop outputs only; storage array carries no reset.
module sub0_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       srst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign do_pop     = pop_i & ~empty_o;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
   assign do_push    = push_i & (~full_o | do_pop);
   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // The head register follows whatever entry will be at the read pointer next cycle.
   always_comb begin
      dout_d = dout_q;
      if (do_push && (empty_o || (do_pop && count_q == CNT_W'(1)))) begin
         dout_d = din_i;
      end else if (do_pop && count_q > CNT_W'(1)) begin
         dout_d = mem_q[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   assign dout_o  = dout_q;
   assign count_o = count_q;

endmodule

// File: rtl/sub0_bit_collect.sv
// Collects one selected bit per beat into a BIT_GROUP_NUM-bit key, gated by the
// mask captured on beat 0, and queues {mask, key} for the lookup stage.
module sub0_bit_collect
   import sub0_bit_pkg::*;
#(
   parameter int BIT_GROUP_NUM = sub0_bit_pkg::BIT_GROUP_NUM,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                     axis_clk,
   input  logic                     areset,
   input  logic [BIT_WIDTH-1:0]     i_bit_8,
   input  logic [BIT_IDX_W-1:0]     i_bit_act_low,
   input  logic                     i_bit_act_low_valid,
   input  logic [BIT_GROUP_NUM-1:0] i_bit_mask,
   output logic [BIT_GROUP_NUM-1:0] o_bit_vec,
   output logic [BIT_GROUP_NUM-1:0] o_bit_mask,
   output logic                     o_bit_vec_valid,
   input  logic                     i_bit_vec_ready,
   output logic                     o_overflow,
   output logic                     o_frag_err
);

   localparam int EW    = 2 * BIT_GROUP_NUM;
   localparam int CNT_W = $clog2(BIT_GROUP_NUM);
   localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BIT_GROUP_NUM - 1);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [BIT_GROUP_NUM-1:0] mask_q, mask_d;
   logic [BIT_GROUP_NUM-1:0] bits_q, bits_d;
   logic                     frag_q, frag_d;
   logic                     ovf_q, ovf_d;

   logic [BIT_GROUP_NUM-1:0] eff_mask;
   logic [BIT_GROUP_NUM-1:0] lane_bit;
   logic                     push, pop;
   logic                     fifo_full, fifo_empty;
   logic [FC_W-1:0]          fifo_count;
   logic [EW-1:0]            push_data, head;

   // Beat 0 uses the live mask because mask_q is only being loaded that cycle.
   assign eff_mask = (state_q == ST_IDLE) ? i_bit_mask : mask_q;

   generate
      for (genvar gi = 0; gi < BIT_GROUP_NUM; gi++) begin : g_lane
         assign lane_bit[gi] = sel_bit(i_bit_8, i_bit_act_low, eff_mask[gi]);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      bits_d  = bits_q;
      frag_d  = 1'b0;
      push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_bit_act_low_valid) begin
               mask_d    = i_bit_mask;
               bits_d    = '0;
               bits_d[0] = lane_bit[0];
               cnt_d     = CNT_W'(1);
               state_d   = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (i_bit_act_low_valid) begin
               bits_d[cnt_q] = lane_bit[cnt_q];
               if (cnt_q == LAST_BEAT) begin
                  push    = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               frag_d  = 1'b1;
               bits_d  = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign push_data = {mask_q, bits_d};
   assign pop       = i_bit_vec_ready & ~fifo_empty;
   assign ovf_d     = ovf_q | (push & fifo_full & ~pop);

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mask_q  <= '0;
         bits_q  <= '0;
         frag_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         bits_q  <= bits_d;
         frag_q  <= frag_d;
         ovf_q   <= ovf_d;
      end
   end

   sub0_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (axis_clk),
      .srst    (areset),
      .push_i  (push),
      .din_i   (push_data),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign o_bit_vec       = head[BIT_GROUP_NUM-1:0];
   assign o_bit_mask      = head[EW-1:BIT_GROUP_NUM];
   assign o_bit_vec_valid = (fifo_count != '0);
   assign o_overflow      = ovf_q;
   assign o_frag_err      = frag_q;

endmodule

// File: tb/tb_sub0_bit_collect.sv
// Bench for sub0_bit_collect: packet-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sub0_bit_collect;

   localparam int N = 4;
   localparam int D = 2;

   logic         axis_clk = 1'b0;
   logic         areset = 1'b1;
   logic [7:0]   i_bit_8 = '0;
   logic [2:0]   i_bit_act_low = '0;
   logic         i_bit_act_low_valid = 1'b0;
   logic [N-1:0] i_bit_mask = '0;
   logic [N-1:0] o_bit_vec, o_bit_mask;
   logic         o_bit_vec_valid;
   logic         i_bit_vec_ready = 1'b0;
   logic         o_overflow, o_frag_err;

   int checks = 0;
   int failures = 0;

   always #5 axis_clk = ~axis_clk;

   sub0_bit_collect #(.BIT_GROUP_NUM(N), .FIFO_DEPTH(D)) dut (
      .axis_clk            (axis_clk),
      .areset              (areset),
      .i_bit_8             (i_bit_8),
      .i_bit_act_low       (i_bit_act_low),
      .i_bit_act_low_valid (i_bit_act_low_valid),
      .i_bit_mask          (i_bit_mask),
      .o_bit_vec           (o_bit_vec),
      .o_bit_mask          (o_bit_mask),
      .o_bit_vec_valid     (o_bit_vec_valid),
      .i_bit_vec_ready     (i_bit_vec_ready),
      .o_overflow          (o_overflow),
      .o_frag_err          (o_frag_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beats of the open packet, the result queue, sticky/pulse flags.
   logic [7:0] m_bytes[$];
   logic [2:0] m_idx[$];
   logic [N-1:0] m_mask;
   logic [2*N-1:0] m_q[$];
   bit m_ovf = 0, m_frag = 0, m_rst = 0, started = 0;

   function automatic logic [2*N-1:0] model_entry();
      logic [N-1:0] vec = '0;
      for (int g = 0; g < N; g++)
         if (m_mask[g] && m_bytes[g][m_idx[g]]) vec |= N'(1) << g;
      return {m_mask, vec};
   endfunction

   always @(posedge axis_clk) begin
      started = 1;
      if (areset) begin
         m_bytes.delete(); m_idx.delete(); m_q.delete();
         m_ovf = 0; m_frag = 0; m_rst = 1;
      end else begin
         bit pop_now, done;
         int sz;
         logic [2*N-1:0] res;
         m_rst = 0; m_frag = 0; done = 0; res = '0;
         sz = m_q.size();
         pop_now = (sz > 0) && i_bit_vec_ready;
         if (i_bit_act_low_valid) begin
            if (m_bytes.size() == 0) m_mask = i_bit_mask;
            m_bytes.push_back(i_bit_8);
            m_idx.push_back(i_bit_act_low);
            if (m_bytes.size() == N) begin
               res = model_entry();
               done = 1;
               m_bytes.delete(); m_idx.delete();
            end
         end else if (m_bytes.size() != 0) begin
            m_frag = 1;
            m_bytes.delete(); m_idx.delete();
         end
         if (pop_now) void'(m_q.pop_front());
         if (done) begin
            if (sz < D || pop_now) m_q.push_back(res);
            else m_ovf = 1;
         end
      end
   end

   always @(negedge axis_clk) begin
      if (started) begin
         chk("valid", o_bit_vec_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            chk("vec", o_bit_vec, m_q[0][N-1:0]);
            chk("mask", o_bit_mask, m_q[0][2*N-1:N]);
         end
         if (m_rst) begin
            chk("rst_vec", o_bit_vec, 0);
            chk("rst_mask", o_bit_mask, 0);
         end
         chk("overflow", o_overflow, m_ovf);
         chk("frag_err", o_frag_err, m_frag);
      end
   end

   task automatic drive_beat(input logic [7:0] b, input logic [2:0] ix, input logic [N-1:0] m);
      i_bit_act_low_valid = 1'b1;
      i_bit_8 = b;
      i_bit_act_low = ix;
      i_bit_mask = m;
      @(negedge axis_clk);
   endtask

   task automatic send_pkt(input logic [31:0] bytes, input logic [11:0] idxs,
                           input logic [N-1:0] m0, input logic [N-1:0] mo);
      for (int g = 0; g < N; g++)
         drive_beat(bytes[8*g +: 8], idxs[3*g +: 3], (g == 0) ? m0 : mo);
   endtask

   task automatic idle(input int n);
      i_bit_act_low_valid = 1'b0;
      repeat (n) @(negedge axis_clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_vec"}, o_bit_vec, 0);
      chk({tag, "_mask"}, o_bit_mask, 0);
      chk({tag, "_valid"}, o_bit_vec_valid, 0);
      chk({tag, "_ovf"}, o_overflow, 0);
      chk({tag, "_frag"}, o_frag_err, 0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      i_bit_act_low_valid = 1'b0;
      @(negedge axis_clk);
      chk_all_zero("reset");
      areset = 1'b0;
   endtask

   // P1 -> vec 0101 mask F, P2 -> vec 1010 mask F, P3 -> vec 0011 mask 3
   localparam logic [31:0] P1_B = 32'h00FF00FF;
   localparam logic [31:0] P2_B = 32'hFF00FF00;
   localparam logic [31:0] P3_B = 32'hFFFFFFFF;

   initial begin
      repeat (3) @(negedge axis_clk);
      chk_all_zero("init");
      areset = 1'b0;

      // single packet, one set bit per byte at the addressed index
      i_bit_vec_ready = 1'b1;
      send_pkt(32'h80040201, {3'd7, 3'd2, 3'd1, 3'd0}, 4'hF, 4'hF);
      chk("t1_valid", o_bit_vec_valid, 1);
      chk("t1_vec", o_bit_vec, 4'b1111);
      chk("t1_mask", o_bit_mask, 4'hF);
      idle(2);

      // mask gating; later-beat mask values have no effect
      send_pkt(32'hFFFFFFFF, {4{3'd3}}, 4'b0101, 4'b1010);
      chk("t2_vec", o_bit_vec, 4'b0101);
      chk("t2_mask", o_bit_mask, 4'b0101);
      idle(2);

      // three back-to-back with downstream stalled
      i_bit_vec_ready = 1'b0;
      send_pkt(P1_B, 12'd0, 4'hF, 4'hF);
      send_pkt(P2_B, 12'd0, 4'hF, 4'hF);
      send_pkt(P3_B, 12'd0, 4'h3, 4'h3);
      i_bit_act_low_valid = 1'b0;
      chk("t3_ovf", o_overflow, 1);
      chk("t3_head1", o_bit_vec, 4'b0101);
      i_bit_vec_ready = 1'b1;
      @(negedge axis_clk);
      chk("t3_valid2", o_bit_vec_valid, 1);
      chk("t3_head2", o_bit_vec, 4'b1010);
      @(negedge axis_clk);
      chk("t3_empty", o_bit_vec_valid, 0);
      do_reset();

      // fragment after three beats
      drive_beat(8'hFF, 3'd0, 4'hF);
      drive_beat(8'hFF, 3'd0, 4'hF);
      drive_beat(8'hFF, 3'd0, 4'hF);
      idle(1);
      chk("t4_frag", o_frag_err, 1);
      chk("t4_nopush", o_bit_vec_valid, 0);
      idle(1);
      chk("t4_frag_once", o_frag_err, 0);
      send_pkt(P2_B, 12'd0, 4'hF, 4'hF);
      chk("t4_next", o_bit_vec, 4'b1010);
      idle(2);

      // full FIFO, pop coincides with the completing beat
      i_bit_vec_ready = 1'b0;
      send_pkt(P1_B, 12'd0, 4'hF, 4'hF);
      send_pkt(P2_B, 12'd0, 4'hF, 4'hF);
      drive_beat(8'hFF, 3'd0, 4'h3);
      drive_beat(8'hFF, 3'd0, 4'h3);
      drive_beat(8'hFF, 3'd0, 4'h3);
      i_bit_vec_ready = 1'b1;
      drive_beat(8'hFF, 3'd0, 4'h3);
      i_bit_vec_ready = 1'b0;
      i_bit_act_low_valid = 1'b0;
      chk("t5_ovf", o_overflow, 0);
      chk("t5_head", o_bit_vec, 4'b1010);
      i_bit_vec_ready = 1'b1;
      @(negedge axis_clk);
      chk("t5_tail_vec", o_bit_vec, 4'b0011);
      chk("t5_tail_mask", o_bit_mask, 4'h3);
      @(negedge axis_clk);
      chk("t5_empty", o_bit_vec_valid, 0);

      // reset during beat 2 with one entry queued
      i_bit_vec_ready = 1'b0;
      send_pkt(P1_B, 12'd0, 4'hF, 4'hF);
      drive_beat(8'hFF, 3'd0, 4'hF);
      drive_beat(8'hFF, 3'd0, 4'hF);
      areset = 1'b1;
      drive_beat(8'hFF, 3'd0, 4'hF);
      areset = 1'b0;
      chk_all_zero("t6");
      i_bit_vec_ready = 1'b1;
      send_pkt(P3_B, 12'd0, 4'h3, 4'h3);
      chk("t6_next_vec", o_bit_vec, 4'b0011);
      chk("t6_next_valid", o_bit_vec_valid, 1);
      idle(2);

      // randomized traffic, checked by the model every cycle
      repeat (3000) begin
         i_bit_act_low_valid = ($urandom_range(0, 15) != 0);
         i_bit_8 = 8'($urandom);
         i_bit_act_low = 3'($urandom);
         i_bit_mask = N'($urandom);
         i_bit_vec_ready = ($urandom_range(0, 2) != 0);
         areset = ($urandom_range(0, 299) == 0);
         @(negedge axis_clk);
      end
      areset = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
